// File: rtl/hub75_bcm_scan_ctrl.sv
// hub75_bcm_scan_ctrl
//   Scan scheduler for a HUB75 LED matrix using binary-coded modulation.
//   For each row pair and bit-plane p, it does three things:
//     - shifts COLS pixels into the panel (two cycles per column),
//     - pulses lat,
//     - unblanks the panel for BASE_ON<<p cycles.
//   Counters then advance to the next plane, or to the next row pair
//   after the last plane.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   en              run scanning; sampled in IDLE and at the end of DISPLAY
//   rd_addr         frame buffer address {row, col}, registered
//   rd_data         pixel word {r0,g0,b0,r1,g1,b1}, one cycle after rd_addr
//   row_addr        panel row-pair select {D,C,B,A}
//   rgb0, rgb1      bit p of the upper / lower half pixel
//   sclk, lat       panel shift clock and latch strobe
//   oe_n            panel output enable, active-low
//   frame_done      one-cycle pulse after the last plane of the last row pair
//   busy            high whenever the scheduler is not idle
module hub75_bcm_scan_ctrl #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 4,
  parameter int PLANES   = 4,
  parameter int BASE_ON  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  output logic [ROW_BITS+$clog2(COLS)-1:0] rd_addr,
  input  logic [6*PLANES-1:0]              rd_data,
  output logic [ROW_BITS-1:0]              row_addr,
  output logic [2:0]                       rgb0,
  output logic [2:0]                       rgb1,
  output logic                             sclk,
  output logic                             lat,
  output logic                             oe_n,
  output logic                             frame_done,
  output logic                             busy
);

  localparam int CB = $clog2(COLS);
  localparam int AW = ROW_BITS + CB;
  localparam int SW = $clog2(2*COLS+2);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int TW = $clog2(BASE_ON) + PLANES;

  localparam logic [SW-1:0] SHIFT_LAST = SW'(2*COLS+1);
  localparam logic [SW-1:0] SHIFT_COLS = SW'(2*COLS);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t              state, state_d;
  logic [ROW_BITS-1:0] row, row_d;
  logic [PW-1:0]       plane, plane_d;
  logic [SW-1:0]       sh_cnt, sh_cnt_d, sh_nxt;
  logic [TW-1:0]       tmr, tmr_d;
  logic [AW-1:0]       rd_addr_d;
  logic [ROW_BITS-1:0] row_addr_d;
  logic [2:0]          rgb0_d, rgb1_d;
  logic                sclk_d, lat_d, oe_n_d, frame_done_d, busy_d;
  logic                last_plane, disp_end;

  logic [PLANES-1:0]   r0, g0, b0, r1, g1, b1;

  assign {r0, g0, b0, r1, g1, b1} = rd_data;

  // Next-state and next-output logic. All panel and frame buffer outputs are
  // registered, so each branch computes what the pins show in the next cycle.
  always_comb begin
    state_d      = state;
    row_d        = row;
    plane_d      = plane;
    sh_cnt_d     = sh_cnt;
    tmr_d        = tmr;
    rd_addr_d    = rd_addr;
    row_addr_d   = row_addr;
    rgb0_d       = rgb0;
    rgb1_d       = rgb1;
    sclk_d       = 1'b0;
    lat_d        = 1'b0;
    oe_n_d       = 1'b1;
    frame_done_d = 1'b0;
    busy_d       = 1'b1;
    sh_nxt       = sh_cnt + SW'(1);
    last_plane   = (plane == PW'(PLANES-1));
    disp_end     = (tmr == ((TW'(BASE_ON) << plane) - TW'(1)));

    unique case (state)
      IDLE: begin
        busy_d = en;
        if (en) begin
          state_d   = SHIFT;
          sh_cnt_d  = '0;
          rd_addr_d = {row, {CB{1'b0}}};
        end
      end

      SHIFT: begin
        sh_cnt_d = sh_nxt;
        // Column c owns cycles 2c and 2c+1. The address is held past the
        // last column rather than wrapping.
        if (sh_nxt < SHIFT_COLS)
          rd_addr_d = {row, sh_nxt[CB:1]};
        // Odd cycles carry the word addressed in the preceding even cycle.
        if (sh_cnt[0] && (sh_cnt < SHIFT_COLS)) begin
          rgb0_d = {r0[plane], g0[plane], b0[plane]};
          rgb1_d = {r1[plane], g1[plane], b1[plane]};
        end
        // The clock rises in the second cycle that rgb is stable, so the
        // data sees one cycle of setup and one cycle of hold.
        sclk_d = !sh_cnt[0] && (sh_cnt >= SW'(2)) && (sh_cnt <= SHIFT_COLS);
        if (sh_cnt == SHIFT_LAST) begin
          state_d    = LATCH;
          lat_d      = 1'b1;
          row_addr_d = row;
        end
      end

      LATCH: begin
        state_d = DISPLAY;
        tmr_d   = '0;
        oe_n_d  = 1'b0;
      end

      DISPLAY: begin
        if (disp_end) begin
          plane_d = last_plane ? '0 : plane + PW'(1);
          if (last_plane) begin
            row_d        = row + ROW_BITS'(1);
            frame_done_d = (row == {ROW_BITS{1'b1}});
          end
          if (en) begin
            state_d   = SHIFT;
            sh_cnt_d  = '0;
            rd_addr_d = {row_d, {CB{1'b0}}};
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          tmr_d  = tmr + TW'(1);
          oe_n_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      plane      <= '0;
      sh_cnt     <= '0;
      tmr        <= '0;
      rd_addr    <= '0;
      row_addr   <= '0;
      rgb0       <= '0;
      rgb1       <= '0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      plane      <= plane_d;
      sh_cnt     <= sh_cnt_d;
      tmr        <= tmr_d;
      rd_addr    <= rd_addr_d;
      row_addr   <= row_addr_d;
      rgb0       <= rgb0_d;
      rgb1       <= rgb1_d;
      sclk       <= sclk_d;
      lat        <= lat_d;
      oe_n       <= oe_n_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: doc/hub75_bcm_scan_ctrl.md
# hub75_bcm_scan_ctrl

Scan scheduler for the 64x32 HUB75 LED matrix, row pairs addressed by A/B/C/D. Reads pixel words from the frame buffer and shifts one bit-plane of a row pair into the panel. It then latches the plane and holds OE active for a binary-weighted time, which gives PLANES-bit-per-channel brightness through binary-coded modulation. It sits between the frame buffer read port and the panel pins and replaces the fixed test-pattern driver.

## Interface
- COLS, 64: columns per row, power of 2
- ROW_BITS, 4: row-pair address width; 2^ROW_BITS row pairs
- PLANES, 4: bits per colour channel
- BASE_ON, 64: OE-active cycles for plane 0; power of 2
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  run scanning; sampled in IDLE and at the end of each DISPLAY
- rd_addr  out  ROW_BITS+log2(COLS)  frame buffer address {row, col}, registered
- rd_data  in  6*PLANES  pixel word {r0,g0,b0,r1,g1,b1}, PLANES bits each; valid one cycle after rd_addr
- row_addr  out  ROW_BITS  panel {D,C,B,A}
- rgb0  out  3  {R0,G0,B0} bit p of the upper-half pixel
- rgb1  out  3  {R1,G1,B1} bit p of the lower-half pixel
- sclk  out  1  panel shift clock
- lat  out  1  panel latch strobe
- oe_n  out  1  panel output enable, active-low (1 = blanked)
- frame_done  out  1  one-cycle pulse after the last plane of the last row pair
- busy  out  1  high in every state except IDLE

## Operation
- Reset values:
  - rd_addr, row_addr, rgb0, rgb1: 0
  - sclk, lat, frame_done, busy: 0
  - oe_n: 1
  - state IDLE; internal row = 0, plane p = 0, column and timer counters 0
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE:
  - oe_n=1.
  - en=1 moves to SHIFT next cycle with the current row and p; otherwise stays in IDLE.
- SHIFT (2*COLS+2 cycles, t=0 at entry):
  - Column c is handled over cycles 2c and 2c+1.
  - rd_addr={row,c} is held during cycles 2c and 2c+1.
  - rd_data is captured at the end of cycle 2c+1: rgb0={r0[p],g0[p],b0[p]}, rgb1={r1[p],g1[p],b1[p]}.
  - rgb is stable for cycles 2c+2 and 2c+3.
  - sclk=1 only in cycle 2c+3, so the data has one full cycle of setup and one cycle of hold.
  - oe_n=1 throughout SHIFT. Panel still shows the previous plane's latched data blanked.
- LATCH (1 cycle):
  - lat=1, oe_n=1.
  - row_addr updates to row in this cycle. It changes only while oe_n=1.
- DISPLAY (BASE_ON<<p cycles):
  - oe_n=0, lat=0, sclk=0.
  - Timer width is log2(BASE_ON)+PLANES bits.
- End of DISPLAY advances the counters:
  - p increments.
  - If p was PLANES-1: p=0 and row increments modulo 2^ROW_BITS.
  - If row wraps from 2^ROW_BITS-1 to 0: frame_done=1 in the first cycle after DISPLAY.
  - Then: en=1 goes to SHIFT, en=0 goes to IDLE, with counters already advanced. Scanning resumes at the next plane and never restarts the frame.
- en deasserted mid-SHIFT/LATCH/DISPLAY has no effect until the end of the current DISPLAY.
- rst asserted in any state forces all reset values immediately. A partially shifted plane is discarded and there is no lat pulse.
- rd_data is ignored outside the capture cycles. Address wrap is not possible because col < COLS.

## Timing
- Per plane: (2*COLS+2) + 1 + BASE_ON*2^p cycles. Defaults give 131 + 64*2^p.
- Per row pair (defaults): 4*131 + 64*15 = 1484 cycles. Per frame: 16*1484 = 23744 cycles.
- Read latency is exactly 1 cycle. The frame buffer must return data for the address it was presented in the previous cycle.
- oe_n=0 and lat=1 never occur in the same cycle. oe_n=0 and sclk=1 never occur in the same cycle.
- First sclk rising edge is at SHIFT t=3. Last sclk is at t=2*COLS+1. LATCH starts at t=2*COLS+2.

## Test plan
- Reset, then en=1 with a frame buffer model holding all pixels 0xFFFFFF: SHIFT begins 1 cycle after en; 64 sclk pulses; rgb0=rgb1=3'b111 at every sclk; lat at t=130; oe_n=0 for 64 cycles; then planes 1..3 get 128, 256 and 512 cycles.
- Pixel col c = c[3:0] in every channel, plane p: the sampled rgb bit at each sclk equals c[p]; rd_addr increments 0..63 with the correct row field.
- Free-running with en=1: frame_done pulses exactly every 23744 cycles; row_addr steps 0..15 then wraps to 0; row_addr changes only in LATCH cycles.
- en dropped mid-SHIFT of row 3, plane 1: the current plane completes including its 128-cycle display, then IDLE; on en=1 scanning resumes at row 3, plane 2.
- rst pulsed at SHIFT t=40: all outputs return to reset values that cycle; no lat occurs; after release with en=1 scanning starts at row 0, plane 0.
- Protocol checker over a full frame: never oe_n=0 together with lat or sclk; row_addr stable while oe_n=0; busy=0 only in IDLE.
